sum_of_n_seq: RTL and testbench

- Sequential, parametrised successor to the combinational sum-of-first-N block.
- Iteratively accumulates either 1+2+…+N or 1²+2²+…+N², one term per clock, under a start/busy/done handshake.
- Output width is sized so the default configuration never truncates.
- Sticky overflow flag covers reduced-width builds.
- Used as a shared arithmetic unit inside the behavioural-model iterative examples.

---
 rtl/sum_of_n_pkg.sv | 13 +
 rtl/sum_term_gen.sv | 18 +
 rtl/sum_of_n_seq.sv | 96 +++++++++
 tb/tb_sum_of_n_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_of_n_pkg.sv
// Shared encodings for the sequential sum-of-first-N unit.
package sum_of_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_LIN = 1'b0;
    localparam logic MODE_SQR = 1'b1;

endpackage

// File: rtl/sum_term_gen.sv
// Term generator for the sum-of-N unit: i (linear mode) or i*i (square mode).
// Kept separate so the multiplier can be replaced by a shift-add variant.
module sum_term_gen
    import sum_of_n_pkg::*;
#(
    parameter int N_W = 8
) (
    input  logic [N_W-1:0]   i,
    input  logic             mode,
    output logic [2*N_W-1:0] term
);

    logic [2*N_W-1:0] i_ext;

    assign i_ext = {{N_W{1'b0}}, i};
    assign term  = (mode == MODE_SQR) ? i_ext * i_ext : i_ext;

endmodule

// File: rtl/sum_of_n_seq.sv
// Iterative 1+..+N or 1^2+..+N^2 accumulator with start/busy/done handshake.
// Define SUM_OF_N_SAT_EN to saturate the result on overflow instead of wrapping.
module sum_of_n_seq
    import sum_of_n_pkg::*;
#(
    parameter int N_W = 8,
    parameter int S_W = 3*N_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic           mode,
    output logic           busy,
    output logic           done,
    output logic [S_W-1:0] sum,
    output logic           ovf
);

    state_t           state;
    logic [N_W-1:0]   n_q;
    logic [N_W-1:0]   i_q;
    logic             mode_q;
    logic [S_W-1:0]   acc;
    logic             ovf_int;
    logic [2*N_W-1:0] term;
    logic [S_W:0]     term_ext;
    logic [S_W:0]     add;

    sum_term_gen #(.N_W(N_W)) u_term (
        .i    (i_q),
        .mode (mode_q),
        .term (term)
    );

    // Fit the raw product to the S_W+1 bit adder: zero-extend or drop high bits.
    generate
        if (S_W + 1 > 2*N_W) begin : g_ext
            assign term_ext = {{(S_W + 1 - 2*N_W){1'b0}}, term};
        end else begin : g_trunc
            assign term_ext = term[S_W:0];
        end
    endgenerate

    assign add = {1'b0, acc} + term_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            n_q     <= '0;
            i_q     <= '0;
            mode_q  <= MODE_LIN;
            acc     <= '0;
            ovf_int <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= n;
                        mode_q  <= mode;
                        acc     <= '0;
                        i_q     <= N_W'(1);
                        ovf_int <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (n == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef SUM_OF_N_SAT_EN
                    acc <= (ovf_int | add[S_W]) ? '1 : add[S_W-1:0];
`else
                    acc <= add[S_W-1:0];
`endif
                    ovf_int <= ovf_int | add[S_W];
                    i_q     <= i_q + 1'b1;
                    if (i_q == n_q)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    sum   <= acc;
                    ovf   <= ovf_int;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_of_n_seq.sv
// Bench for sum_of_n_seq: default build (S_W=24) and a narrow S_W=8 build side by side.
module tb_sum_of_n_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       st [2];
    logic [7:0] nn [2];
    logic       md [2];

    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [23:0] sum0;
    logic [7:0]  sum1;

    sum_of_n_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .n(nn[0]), .mode(md[0]),
        .busy(busy0), .done(done0), .sum(sum0), .ovf(ovf0)
    );

    sum_of_n_seq #(.N_W(8), .S_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .n(nn[1]), .mode(md[1]),
        .busy(busy1), .done(done1), .sum(sum1), .ovf(ovf1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [63:0] g_sum(input int d);
        return (d == 0) ? 64'(sum0) : 64'(sum1);
    endfunction
    function automatic logic g_busy(input int d);
        return (d == 0) ? busy0 : busy1;
    endfunction
    function automatic logic g_done(input int d);
        return (d == 0) ? done0 : done1;
    endfunction
    function automatic logic g_ovf(input int d);
        return (d == 0) ? ovf0 : ovf1;
    endfunction

`ifdef SUM_OF_N_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Reference arithmetic: term trimmed to S+1 bits, add at S+1 bits, bit S is the carry.
    task automatic calc(input int nv, input bit m, input int s,
                        output longint res, output bit o);
        longint acc, t, r, m1;
        acc = 0; o = 0;
        m1 = (longint'(1) << (s + 1)) - 1;
        for (int i = 1; i <= nv; i++) begin
            t = m ? longint'(i) * i : longint'(i);
            t = t & m1;
            r = (acc + t) & m1;
            if (r[s]) o = 1'b1;
            acc = r & ((longint'(1) << s) - 1);
            if (SAT && o) acc = (longint'(1) << s) - 1;
        end
        res = acc;
    endtask

    // Transaction-level model: an accepted request finishes its done edge n+1 clocks later.
    int          s_w [2] = '{24, 8};
    int          rem [2] = '{-1, -1};
    longint      p_sum [2];
    bit          p_ovf [2];
    logic        e_busy [2], e_done [2], e_ovf [2];
    logic [63:0] e_sum [2];
    bit          armed = 1'b0;
    bit          idle_m;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                rem[d] = -1;
                e_busy[d] = 0; e_done[d] = 0; e_sum[d] = 0; e_ovf[d] = 0;
            end else begin
                idle_m = (rem[d] < 0);
                e_done[d] = 0;
                if (rem[d] == 0) begin
                    e_done[d] = 1; e_sum[d] = p_sum[d]; e_ovf[d] = p_ovf[d];
                    rem[d] = -1;
                end else if (rem[d] > 0) begin
                    rem[d]--;
                end
                if (idle_m && st[d]) begin
                    calc(int'(nn[d]), md[d], s_w[d], p_sum[d], p_ovf[d]);
                    rem[d] = int'(nn[d]);
                end
                e_busy[d] = (rem[d] >= 0);
            end
        end
        if (!rst_n) armed = 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("done[%0d]", d), 64'(g_done(d)), 64'(e_done[d]));
                chk($sformatf("busy[%0d]", d), 64'(g_busy(d)), 64'(e_busy[d]));
                chk($sformatf("sum[%0d]",  d), g_sum(d), e_sum[d]);
                chk($sformatf("ovf[%0d]",  d), 64'(g_ovf(d)), 64'(e_ovf[d]));
            end
        end
    end

    // Issue one request; c returns negedges from the accepting edge until done is seen.
    task automatic op(input int d, input int nv, input bit m, input int glitch, output int c);
        @(negedge clk);
        st[d] = 1'b1; nn[d] = 8'(nv); md[d] = m;
        @(negedge clk);
        st[d] = 1'b0;
        c = 0;
        while (!g_done(d) && c < 400) begin
            @(negedge clk);
            c++;
            if (glitch >= 0) begin
                nn[d] = (c == glitch) ? 8'd3 : 8'($urandom);
                md[d] = 1'($urandom);
                st[d] = (c == glitch);
            end
        end
        st[d] = 1'b0;
        if (c >= 400) chk("done_timeout", 64'(c), 64'(nv + 1));
    endtask

    initial begin
        int     c;
        longint r;
        bit     o;
        bit     seen_done;

        for (int d = 0; d < 2; d++) begin
            st[d] = 1'b0; nn[d] = '0; md[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_sum",  64'(sum0),  64'd0);
        chk("rst_ovf",  64'(ovf1),  64'd0);
        rst_n = 1'b1;

        calc(4, 1'b0, 24, r, o);   chk("model_lin4", 64'(r), 64'd10);
        calc(255, 1'b1, 24, r, o); chk("model_sqr255", 64'(r), 64'd5559680);
        calc(23, 1'b0, 8, r, o);   chk("model_w8_n23", 64'(r), SAT ? 64'd255 : 64'd20);

        op(0, 4, 1'b0, -1, c);
        chk("lat_n4", 64'(c), 64'd5);
        chk("sum_n4", 64'(sum0), 64'd10);
        chk("ovf_n4", 64'(ovf0), 64'd0);
        @(negedge clk);
        chk("busy_after_done", 64'(busy0), 64'd0);
        chk("done_one_cycle", 64'(done0), 64'd0);

        op(0, 0, 1'b1, -1, c);
        chk("lat_n0", 64'(c), 64'd1);
        chk("sum_n0", 64'(sum0), 64'd0);

        op(0, 255, 1'b0, -1, c);
        chk("sum_lin255", 64'(sum0), 64'd32640);
        op(0, 255, 1'b1, -1, c);
        chk("sum_sqr255", 64'(sum0), 64'd5559680);
        chk("ovf_sqr255", 64'(ovf0), 64'd0);

        op(1, 23, 1'b0, -1, c);
        chk("w8_sum_n23", 64'(sum1), SAT ? 64'd255 : 64'd20);
        chk("w8_ovf_n23", 64'(ovf1), 64'd1);
        op(1, 20, 1'b0, -1, c);
        chk("w8_sum_n20", 64'(sum1), 64'd210);
        chk("w8_ovf_n20", 64'(ovf1), 64'd0);

        op(0, 10, 1'b0, 3, c);
        chk("sum_ignore_start", 64'(sum0), 64'd55);
        chk("lat_ignore_start", 64'(c), 64'd11);

        // Abort a long operation with a one-cycle reset.
        @(negedge clk);
        st[0] = 1'b1; nn[0] = 8'd100; md[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_sum",  64'(sum0),  64'd0);
        seen_done = 1'b0;
        repeat (110) begin
            @(negedge clk);
            if (done0) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        op(0, 3, 1'b1, -1, c);
        chk("sum_after_abort", 64'(sum0), 64'd14);

        for (int k = 0; k < 16; k++) begin
            int d, nv;
            bit m;
            d  = k % 2;
            nv = (d == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
            m  = 1'($urandom_range(0, 1));
            op(d, nv, m, (k % 3 == 0) ? 2 : -1, c);
            calc(nv, m, s_w[d], r, o);
            chk($sformatf("rnd_sum[%0d]", k), g_sum(d), 64'(r));
            chk($sformatf("rnd_ovf[%0d]", k), 64'(g_ovf(d)), 64'(o));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
